// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the multi-channel core controller:
// FSM state encoding, condition-flag bit positions and default widths.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_MC,
        ST_PROCC,
        ST_DRAIN,
        ST_ERR
    } state_t;

    localparam int COND_HAS_DATA     = 3;
    localparam int COND_VALID_DATA   = 2;
    localparam int COND_HAS_DATA_R   = 1;
    localparam int COND_VALID_DATA_R = 0;

    localparam int DEF_NUM_CH = 2;
    localparam int DEF_ADDR_W = 6;
    localparam int DEF_INST_W = 5;

    // A single channel still needs a one-bit grant index.
    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/core_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first requester above last_grant,
// wrapping around, so the most recent winner has lowest priority.
module core_ctrl_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int GW      = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      last_grant,
    output logic [GW-1:0]      grant,
    output logic               any_req
);

    int idx;

    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_grant) + i) % NUM_REQ;
            if (!any_req && req[idx]) begin
                grant   = GW'(idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_ctrl_multi.sv
// Multi-channel core controller: round-robin job arbitration, burst write
// addressing and load/process/drain sequencing. Optional: CORE_CTRL_ERR_RETRY_EN.
module core_ctrl_multi
    import core_ctrl_pkg::*;
#(
    parameter int  NUM_CH = DEF_NUM_CH,
    parameter int  ADDR_W = DEF_ADDR_W,
    parameter int  INST_W = DEF_INST_W,
    localparam int GW     = grant_width(NUM_CH)
) (
    input  logic                     ctrl_clk,
    input  logic                     ctrl_reset,
    input  logic [NUM_CH-1:0]        ctrl_valid_inst,
    output logic [NUM_CH-1:0]        ctrl_inst_ready,
    input  logic [NUM_CH*INST_W-1:0] ctrl_instruction,
    input  logic [NUM_CH*ADDR_W-1:0] ctrl_data_address_in,
    input  logic [NUM_CH-1:0]        ctrl_valid_data,
    output logic [NUM_CH-1:0]        ctrl_data_ready,
    input  logic [NUM_CH-1:0]        ctrl_last_data,
    output logic [NUM_CH*4-1:0]      ctrl_data_contition,
    output logic [GW-1:0]            ctrl_grant,
    output logic [INST_W-1:0]        ctrl_inst_out,
    output logic [ADDR_W-1:0]        mc_data_address_out,
    output logic                     mc_we,
    input  logic                     mc_err,
    input  logic                     mc_cont_procc,
    input  logic                     procc_done,
    input  logic                     mc_data_done,
    output logic                     ctrl_err
);

    state_t              state;
    logic [NUM_CH-1:0]   full;
    logic [NUM_CH-1:0]   accept;
    logic [INST_W-1:0]   inst_reg [NUM_CH];
    logic [ADDR_W-1:0]   addr_reg [NUM_CH];
    logic [3:0]          cond     [NUM_CH];
    logic [GW-1:0]       last_grant;
    logic [GW-1:0]       arb_grant;
    logic                any_req;
    logic                beat;
`ifdef CORE_CTRL_ERR_RETRY_EN
    logic                retried;
`endif

    core_ctrl_rr_arbiter #(
        .NUM_REQ (NUM_CH),
        .GW      (GW)
    ) u_arb (
        .req        (full),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .any_req    (any_req)
    );

    assign ctrl_inst_ready = (state == ST_ERR) ? '0 : ~full;
    assign accept          = ctrl_valid_inst & ctrl_inst_ready;
    assign beat            = (state == ST_LOAD) && ctrl_valid_data[ctrl_grant];
    assign mc_we           = beat;
    assign ctrl_inst_out   = (state == ST_PROCC) ? inst_reg[ctrl_grant] : '0;

    always_comb begin
        ctrl_data_ready     = '0;
        ctrl_data_contition = '0;
        if (state == ST_LOAD)
            ctrl_data_ready[ctrl_grant] = 1'b1;
        for (int c = 0; c < NUM_CH; c++)
            ctrl_data_contition[c*4 +: 4] = cond[c];
    end

    // Holding-register payload; validity is tracked by full[].
    always_ff @(posedge ctrl_clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (accept[c]) begin
                inst_reg[c] <= ctrl_instruction[c*INST_W +: INST_W];
                addr_reg[c] <= ctrl_data_address_in[c*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge ctrl_clk or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state               <= ST_IDLE;
            full                <= '0;
            for (int c = 0; c < NUM_CH; c++)
                cond[c] <= '0;
            last_grant          <= GW'(NUM_CH - 1);
            ctrl_grant          <= '0;
            mc_data_address_out <= '0;
            ctrl_err            <= 1'b0;
`ifdef CORE_CTRL_ERR_RETRY_EN
            retried             <= 1'b0;
`endif
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (accept[c]) begin
                    full[c] <= 1'b1;
                    cond[c] <= '0;
                end
            end

            // An error outranks every other transition of an active job.
            if (mc_err && state != ST_IDLE && state != ST_ERR) begin
`ifdef CORE_CTRL_ERR_RETRY_EN
                if (!retried) begin
                    retried                          <= 1'b1;
                    state                            <= ST_LOAD;
                    mc_data_address_out              <= addr_reg[ctrl_grant];
                    cond[ctrl_grant][COND_HAS_DATA]   <= 1'b0;
                    cond[ctrl_grant][COND_VALID_DATA] <= 1'b0;
                end else begin
                    state    <= ST_ERR;
                    ctrl_err <= 1'b1;
                end
`else
                state    <= ST_ERR;
                ctrl_err <= 1'b1;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (any_req) begin
                            ctrl_grant          <= arb_grant;
                            last_grant          <= arb_grant;
                            mc_data_address_out <= addr_reg[arb_grant];
                            state               <= ST_LOAD;
`ifdef CORE_CTRL_ERR_RETRY_EN
                            retried             <= 1'b0;
`endif
                        end
                    end
                    ST_LOAD: begin
                        if (beat) begin
                            mc_data_address_out           <= mc_data_address_out + 1'b1;
                            cond[ctrl_grant][COND_HAS_DATA] <= 1'b1;
                            if (ctrl_last_data[ctrl_grant]) begin
                                cond[ctrl_grant][COND_VALID_DATA] <= 1'b1;
                                state                            <= ST_WAIT_MC;
                            end
                        end
                    end
                    ST_WAIT_MC: begin
                        if (mc_cont_procc) begin
                            cond[ctrl_grant][COND_HAS_DATA_R] <= 1'b1;
                            state                            <= ST_PROCC;
                        end
                    end
                    ST_PROCC: begin
                        if (procc_done) begin
                            cond[ctrl_grant][COND_VALID_DATA_R] <= 1'b1;
                            state                              <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (mc_data_done) begin
                            full[ctrl_grant]                   <= 1'b0;
                            cond[ctrl_grant][COND_HAS_DATA_R]   <= 1'b0;
                            cond[ctrl_grant][COND_VALID_DATA_R] <= 1'b0;
                            state                              <= ST_IDLE;
                        end
                    end
                    ST_ERR: ;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/core_ctrl_multi.md
# core_ctrl_multi

Multi-channel successor to the single-channel core controller in the DMA/memory-controller stage. It accepts instruction/data requests from NUM_CH independent requesters and arbitrates them round-robin into one shared memory-controller/processing path. It generates burst write addresses with wrap-around and sequences each job through load, process and drain phases. Per-channel data-condition flags report job progress back to each requester.

## Interface
- NUM_CH, 2, number of requester channels (1..8)
- ADDR_W, 6, memory address width
- INST_W, 5, instruction width [FPU_OP|ROUND_MODE]
- ctrl_clk  in  1  single clock, rising edge
- ctrl_reset  in  1  asynchronous, active-low reset
- ctrl_valid_inst  in  NUM_CH  per-channel instruction valid
- ctrl_inst_ready  out  NUM_CH  instruction holding register empty
- ctrl_instruction  in  NUM_CH*INST_W  flattened instructions; channel c at [c*INST_W +: INST_W]
- ctrl_data_address_in  in  NUM_CH*ADDR_W  flattened burst start addresses
- ctrl_valid_data  in  NUM_CH  data beat valid
- ctrl_data_ready  out  NUM_CH  beat accepted; only the granted channel in LOAD
- ctrl_last_data  in  NUM_CH  qualifies the final beat of a burst
- ctrl_data_contition  out  NUM_CH*4  per channel [HAS_DATA|VALID_DATA|HAS_DATA_R|VALID_DATA_R]
- ctrl_grant  out  $clog2(NUM_CH) (min 1)  channel currently owning the path
- ctrl_inst_out  out  INST_W  instruction of the granted job, valid in PROCC
- mc_data_address_out  out  ADDR_W  memory write address
- mc_we  out  1  memory write enable
- mc_err  in  1  memory-controller error
- mc_cont_procc  in  1  memory controller hands data to processing
- procc_done  in  1  processing finished
- mc_data_done  in  1  result write-back complete
- ctrl_err  out  1  sticky error; cleared only by reset

## Operation
- Each channel has a one-entry holding register for instruction and start address. An instruction is accepted when ctrl_valid_inst[c] and ctrl_inst_ready[c] are both high. Acceptance clears all four of that channel's condition bits.
- FSM states: IDLE, LOAD, WAIT_MC, PROCC, DRAIN, ERR.
- IDLE: if any holding register is full, the round-robin arbiter grants one channel, searching upward from last_grant+1. Transition to LOAD; mc_data_address_out is set to that channel's start address.
- LOAD: ctrl_data_ready[grant]=1. Each accepted beat asserts mc_we for the same cycle at the current address, then the address increments modulo 2^ADDR_W. The first beat sets HAS_DATA. A beat with last_data sets VALID_DATA and moves to WAIT_MC.
- WAIT_MC: mc_cont_procc sets HAS_DATA_R and moves to PROCC.
- PROCC: ctrl_inst_out is driven from the granted channel's instruction. procc_done sets VALID_DATA_R and moves to DRAIN.
- DRAIN: mc_data_done frees the holding register (ctrl_inst_ready[grant] rises the next cycle), clears HAS_DATA_R and VALID_DATA_R, and returns to IDLE.
- mc_err in any non-IDLE state moves to ERR and sets ctrl_err. ERR is absorbing until reset; all ready outputs are 0 and mc_we is 0.
- Simultaneous inputs: mc_err has priority over every other transition. A procc_done seen in WAIT_MC is ignored. A beat with last_data accepted on the same cycle as the first beat sets both HAS_DATA and VALID_DATA.

## Timing
- Reset values: ctrl_inst_ready all 1; every other output 0; last_grant = NUM_CH-1, so channel 0 wins first.
- Latency from instruction accept to LOAD: 2 cycles (register fill, then IDLE grant).
- mc_we is combinational from (state==LOAD & ctrl_valid_data[grant]). The address register updates on the same clock edge.
- A full burst of N beats occupies exactly N LOAD cycles when valid is held high.
- Asserting ctrl_reset mid-job aborts immediately: holding registers are emptied and condition bits cleared. No partial write is issued after the reset edge.

## Configuration
- CORE_CTRL_ERR_RETRY_EN defined: the first mc_err of a job returns to LOAD and restores the start address, so the requester must resend the burst. HAS_DATA and VALID_DATA are cleared. A second mc_err in the same job goes to ERR.
- Undefined: any mc_err goes directly to ERR.

## Structure
- core_ctrl_pkg holds:
  - the state enum,
  - the condition bit index constants (COND_HAS_DATA=3, COND_VALID_DATA=2, COND_HAS_DATA_R=1, COND_VALID_DATA_R=0),
  - the default widths.
- Sub-module: core_ctrl_rr_arbiter, a parametrised round-robin arbiter with request vector, last-grant pointer, grant index and any_req.

## Test plan
- Single channel: channel 0 sends inst 5'b00011 with addr 6'd60 and a 6-beat burst -> mc_we on addresses 60,61,62,63,0,1, then VALID_DATA=1.
- Full handshake: drive mc_cont_procc, procc_done, mc_data_done in turn -> condition bits step 1100 -> 1110 -> 1111 -> 1100; ctrl_inst_ready[0] returns to 1.
- Contention: channels 0 and 1 both present instructions in the same cycle -> grant order 0,1,0,1 across four jobs; a non-granted channel's ctrl_data_ready stays 0.
- Error: mc_err during PROCC -> ctrl_err=1, state ERR, no further mc_we. With CORE_CTRL_ERR_RETRY_EN, the first error instead restarts LOAD at the start address.
- Reset mid-LOAD after 3 of 8 beats -> all outputs return to reset values within the same cycle; the next job starts cleanly at its own address.
- Simultaneous mc_err and last_data in LOAD -> ERR taken; VALID_DATA is not set.
